// File: rtl/l2_line_server.sv
// rtl/l2_line_server.sv - L1 I-cache line-fill responder with pipelined word reads from backing memory
module l2_line_server #(
    parameter int data_width    = 32,
    parameter int address_width = 32,
    parameter int block_size    = 32,
    localparam int offset_width    = $clog2(data_width * block_size / 8),
    localparam int line_addr_width = address_width - offset_width,
    localparam int cache_width     = block_size * data_width
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ADDR_TO_L2_VALID,
    input  logic [line_addr_width-1:0] ADDR_TO_L2,
    output logic [cache_width-1:0]     DATA_FROM_L2,
    output logic                       DATA_FROM_L2_VALID,
    output logic                       MEM_RD_REQ,
    output logic [address_width-1:0]   MEM_ADDR,
    input  logic                       MEM_RD_READY,
    input  logic [data_width-1:0]      MEM_RDATA,
    input  logic                       MEM_RDATA_VALID,
    output logic                       BUSY,
    output logic                       REQ_OVERFLOW,
    output logic                       RESP_ERR
);
    localparam int cnt_width = $clog2(block_size) + 1;
    localparam logic [cnt_width-1:0]     cnt_full   = cnt_width'(block_size);
    localparam logic [cnt_width-1:0]     cnt_last   = cnt_width'(block_size - 1);
    localparam logic [address_width-1:0] word_bytes = address_width'(data_width / 8);

    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

    state_t                     state, next_state;
    logic [line_addr_width-1:0] queue [2];
    logic [1:0]                 q_count;
    logic                       pop, push_ok, issue_fire, ret_ok;
    logic [address_width-1:0]   base;
    logic [cnt_width-1:0]       issue_cnt, ret_cnt;
    logic [cache_width-1:0]     line;
    logic                       overflow, resp_err;

    assign pop        = (state == IDLE) && (q_count != 2'd0);
    assign push_ok    = ADDR_TO_L2_VALID && ((q_count < 2'd2) || pop);
    assign issue_fire = MEM_RD_REQ && MEM_RD_READY;
    // A return is only legal while a read is outstanding in this fill.
    assign ret_ok     = (state == FETCH) && MEM_RDATA_VALID && (ret_cnt != issue_cnt);

    assign MEM_RD_REQ         = (state == FETCH) && (issue_cnt < cnt_full);
    assign MEM_ADDR           = base + address_width'(issue_cnt) * word_bytes;
    assign DATA_FROM_L2       = line;
    assign DATA_FROM_L2_VALID = (state == DELIVER);
    assign BUSY               = (state != IDLE) || (q_count != 2'd0);
    assign REQ_OVERFLOW       = overflow;
    assign RESP_ERR           = resp_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop) next_state = FETCH;
            FETCH:   if (ret_ok && (ret_cnt == cnt_last)) next_state = DELIVER;
            DELIVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Head always lives in queue[0]; a simultaneous pop and push on a full queue shifts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_count  <= 2'd0;
            queue[0] <= '0;
            queue[1] <= '0;
        end else begin
            case ({pop, push_ok})
                2'b10: begin
                    queue[0] <= queue[1];
                    q_count  <= q_count - 2'd1;
                end
                2'b01: begin
                    queue[q_count[0]] <= ADDR_TO_L2;
                    q_count           <= q_count + 2'd1;
                end
                2'b11: begin
                    if (q_count == 2'd2) begin
                        queue[0] <= queue[1];
                        queue[1] <= ADDR_TO_L2;
                    end else begin
                        queue[0] <= ADDR_TO_L2;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            line      <= '0;
            overflow  <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            if (ADDR_TO_L2_VALID && !push_ok) overflow <= 1'b1;
            if (MEM_RDATA_VALID && !ret_ok) resp_err <= 1'b1;
            if (pop) begin
                base      <= {queue[0], {offset_width{1'b0}}};
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if (issue_fire) issue_cnt <= issue_cnt + 1'b1;
                if (ret_ok) begin
                    ret_cnt <= ret_cnt + 1'b1;
                    for (int i = 0; i < block_size; i++) begin
                        if (ret_cnt == cnt_width'(i)) line[i*data_width +: data_width] <= MEM_RDATA;
                    end
                end
            end
        end
    end
endmodule

// File: doc/l2_line_server.md
# l2_line_server

Line-fill responder for the L1 instruction cache's miss port. It accepts single-cycle line requests (`ADDR_TO_L2_VALID`/`ADDR_TO_L2`) and fetches the line word by word from a word-wide backing-memory read port, with reads pipelined. It assembles the full line and returns it as one `DATA_FROM_L2` beat with a one-cycle `DATA_FROM_L2_VALID` pulse. It sits between the Icache and the memory subsystem; its line-side port names match the Icache's, so they hook up one-to-one.

## Interface
- `data_width`, 32, memory word width and Icache word width.
- `address_width`, 32, byte address width.
- `block_size`, 32, words per cache line.
- Localparam `offset_width` = clog2(data_width*block_size/8), 7 by default.
- Localparam `line_addr_width` = address_width - offset_width.
- Localparam `cache_width` = block_size*data_width.
- Clocking: one clock; reset is synchronous and active-high.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ADDR_TO_L2_VALID`  in  1  single-cycle line request strobe.
- `ADDR_TO_L2`  in  line_addr_width  line address (byte address >> offset_width).
- `DATA_FROM_L2`  out  cache_width  assembled line; word i at bits [i*data_width +: data_width].
- `DATA_FROM_L2_VALID`  out  1  one-cycle pulse; `DATA_FROM_L2` is complete in that cycle.
- `MEM_RD_REQ`  out  1  word read request.
- `MEM_ADDR`  out  address_width  byte address of the requested word.
- `MEM_RD_READY`  in  1  memory accepts the request this cycle.
- `MEM_RDATA`  in  data_width  read data, returned in order.
- `MEM_RDATA_VALID`  in  1  `MEM_RDATA` valid.
- `BUSY`  out  1  state != IDLE or request queue non-empty.
- `REQ_OVERFLOW`  out  1  sticky; a request was dropped because the queue was full.
- `RESP_ERR`  out  1  sticky; `MEM_RDATA_VALID` arrived with no read outstanding.

## Operation
- **Request queue:** 2-entry FIFO of line addresses.
  - A push happens on any cycle with `ADDR_TO_L2_VALID`=1.
  - The push is accepted if count<2, or if count==2 and a pop happens the same cycle.
  - Otherwise the request is dropped and `REQ_OVERFLOW` is set.
- **FSM states:** IDLE, FETCH, DELIVER.
- **IDLE:**
  - If the queue is non-empty: pop, load `base` = {line addr, offset_width'b0}, clear `issue_cnt` and `ret_cnt`, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH, issue side:**
  - `MEM_RD_REQ` = (issue_cnt < block_size), combinational from state and counter.
  - `MEM_ADDR` = base + issue_cnt*(data_width/8). Address arithmetic is modulo 2^address_width.
  - `issue_cnt` increments on each cycle with `MEM_RD_REQ & MEM_RD_READY`.
- **FETCH, return side:**
  - On `MEM_RDATA_VALID`, write `MEM_RDATA` into line word `ret_cnt`, then increment `ret_cnt`.
  - When the returned word is word block_size-1, go to DELIVER.
- **DELIVER:** `DATA_FROM_L2_VALID`=1 for exactly this cycle, then go to IDLE.
- **Line register:** holds its value after delivery until overwritten word by word by the next fill.
- **Counters:** `issue_cnt` and `ret_cnt` are clog2(block_size)+1 bits wide. `issue_cnt` saturates at block_size, so no further requests are issued.
- **Spurious data:** `MEM_RDATA_VALID` with ret_cnt == issue_cnt, or in IDLE or DELIVER, is ignored and sets `RESP_ERR`. No line word changes.
- **Queued requests:** a request arriving during FETCH or DELIVER is queued and served after the return to IDLE. Requests are never merged or deduplicated.

## Timing
- **Reset values:**
  - `DATA_FROM_L2` = 0, `DATA_FROM_L2_VALID` = 0, `MEM_RD_REQ` = 0.
  - `MEM_ADDR` = 0, `BUSY` = 0, `REQ_OVERFLOW` = 0, `RESP_ERR` = 0.
  - Queue empty, state IDLE, counters 0.
- **Reset mid-fill:** aborts the fill; returns arriving after reset are counted as spurious (`RESP_ERR`).
- **Request to fetch start:**
  - A request strobed in cycle t is in the queue in cycle t+1.
  - The pop happens at the end of cycle t+1.
  - FETCH starts in cycle t+2, with `MEM_RD_REQ` high in t+2.
- **Minimum latency:** with `MEM_RD_READY`=1 and data one cycle after accept:
  - Issues occur in t+2 .. t+block_size+1.
  - Returns occur in t+3 .. t+block_size+2.
  - `DATA_FROM_L2_VALID` is high in t+block_size+3, which is t+35 at defaults.
- **Back-to-back:** one IDLE cycle between DELIVER and the next FETCH. Minimum gap between valid pulses is block_size+3.
- **Memory stall:** `MEM_RD_READY` low holds `MEM_ADDR` and `MEM_RD_REQ` stable.
- **Outstanding reads:** returns may overlap issues. Outstanding reads = issue_cnt - ret_cnt, up to block_size.
- **DELIVER:** the queue can still be pushed in DELIVER; a new push is not popped until IDLE.

## Test plan
- **Single fill:** reset; pulse request with line addr 0x0000_0020. Memory returns data = byte address.
  - `MEM_ADDR` sequence is 0x1000, 0x1004, ... 0x107C.
  - `DATA_FROM_L2_VALID` rises exactly 35 cycles after the strobe.
  - Word 5 of `DATA_FROM_L2` = 0x1014.
- **Stalled memory:** `MEM_RD_READY` toggles 1,0,0,1 and data latency is 3 cycles.
  - The line is correct.
  - `MEM_ADDR` holds during stalls.
  - Exactly 32 accepted requests; exactly one valid pulse.
- **Queueing:** three requests (A, B, C) in consecutive cycles during a fill.
  - Lines A and B are delivered in order.
  - C is dropped (`REQ_OVERFLOW`=1); exactly 2 valid pulses.
  - `BUSY` falls after B's DELIVER.
- **Full-queue pop:** request arrives while the queue is full, in the same cycle as an IDLE pop.
  - The request is accepted and `REQ_OVERFLOW` stays 0.
- **Spurious data:** `MEM_RDATA_VALID` pulsed in IDLE.
  - `RESP_ERR`=1 and `DATA_FROM_L2` is unchanged.
- **Reset abort:** reset at word 10 of a fill, then a new request for line 0x7F.
  - No valid pulse for the aborted line.
  - The new line is delivered correctly from `MEM_ADDR` 0x3F80.
